npc_sequencer: RTL and testbench

- Drives the PC/nPC pair for the SPARC-style delayed-branch pipeline.
- Produces the fetch address each cycle, advances PC<-nPC on accepted fetches, and computes the next nPC from sequential, branch, jmpl and trap redirects.
- Handles annulled delay slots.
- Sits between decode/branch-resolve (redirect source) and the instruction memory fetch port.

---
 rtl/npc_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_npc_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_sequencer.sv
// npc_sequencer
// -----------------------------------------------------------------------------
// This block holds the PC/nPC pair for a SPARC-style delayed-branch front end.
// Each cycle it presents a fetch address. On an accepted fetch it advances
// PC <- nPC. It works out the next nPC from these sources:
//   - sequential flow (nPC + 4)
//   - a branch or jmpl redirect held in a one-entry pending register
//   - an immediate trap redirect
// It also tracks whether the instruction in a delay slot is annulled.
//
// Optional feature: define NPC_TRACE_EN to build the advance counter on
// adv_count. When it is undefined, adv_count is tied to zero.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   stall        pipeline hold; no advance while high
//   fetch_valid  fetch request valid (high in RUN)
//   fetch_ready  imem accepts the fetch this cycle
//   pc, npc      current and next fetch address
//   fetch_annul  the fetch at pc is a squashed delay slot
//   br_*         one-cycle branch-resolve pulse with taken/always/annul/target
//   jmpl_*       one-cycle jmpl/rett redirect pulse with target
//   trap_*       one-cycle trap pulse with handler vector
//   redir_busy   a redirect is pending; no new br/jmpl pulse allowed
//   misalign     one-cycle pulse: an applied target had bits[1:0] != 0
//   adv_count    number of advances since reset (NPC_TRACE_EN only)
// -----------------------------------------------------------------------------
module npc_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] RESET_NPC      = 32'h0000_0004,
    parameter int          TRAP_FLUSH_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        fetch_annul,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        br_always,
    input  logic        br_annul,
    input  logic [31:0] br_target,
    input  logic        jmpl_valid,
    input  logic [31:0] jmpl_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_vector,
    output logic        redir_busy,
    output logic        misalign,
    output logic [31:0] adv_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // The flush counter counts down to zero, so it is loaded with one less
    // than the number of dark cycles.
    localparam logic [1:0] FLUSH_LOAD = 2'(TRAP_FLUSH_CYC - 1);

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

    state_t      state_q, state_nx;
    logic [1:0]  flush_q, flush_nx;
    logic [31:0] pc_q, pc_nx;
    logic [31:0] npc_q, npc_nx;
    logic        annul_q, annul_nx;
    logic        misalign_q, misalign_nx;
    logic        pend_q, pend_nx;

    // Pending redirect payload. It is only meaningful while pend_q is set.
    logic        pj_q;      // pending is a jmpl
    logic        pt_q;      // branch taken (br_taken | br_always)
    logic        pal_q;     // branch always (ba)
    logic        pa_q;      // branch annul bit
    logic [31:0] ptgt_q;

    logic        capture;
    logic        advance;

    // The redirect that applies on this cycle's advance. It is either the
    // held entry or a pulse arriving in the same cycle.
    logic        eff_v;
    logic        eff_jmpl;
    logic        eff_taken;
    logic        eff_always;
    logic        eff_annul;
    logic [31:0] eff_tgt;

    assign capture = (br_valid | jmpl_valid) & ~pend_q;
    assign advance = (state_q == RUN) & fetch_ready & ~stall & ~trap_valid;

    assign eff_v      = pend_q | capture;
    assign eff_jmpl   = pend_q ? pj_q   : jmpl_valid;
    assign eff_taken  = pend_q ? pt_q   : (br_taken | br_always);
    assign eff_always = pend_q ? pal_q  : br_always;
    assign eff_annul  = pend_q ? pa_q   : br_annul;
    assign eff_tgt    = pend_q ? ptgt_q : (jmpl_valid ? jmpl_target : br_target);

    always_comb begin
        state_nx    = state_q;
        flush_nx    = flush_q;
        pc_nx       = pc_q;
        npc_nx      = npc_q;
        annul_nx    = annul_q;
        pend_nx     = pend_q | capture;
        misalign_nx = 1'b0;

        case (state_q)
            BOOT:    state_nx = RUN;
            RUN:     state_nx = RUN;
            FLUSH: begin
                if (flush_q == 2'd0) begin
                    state_nx = RUN;
                end else begin
                    flush_nx = flush_q - 2'd1;
                end
            end
            default: state_nx = BOOT;
        endcase

        if (advance) begin
            pc_nx    = npc_q;
            npc_nx   = npc_q + 32'd4;
            annul_nx = 1'b0;
            pend_nx  = 1'b0;
            if (eff_v) begin
                if (eff_jmpl) begin
                    npc_nx      = align(eff_tgt);
                    misalign_nx = misaligned(eff_tgt[1:0]);
                end else if (eff_taken) begin
                    // Only ba,a squashes its delay slot when taken.
                    npc_nx      = align(eff_tgt);
                    annul_nx    = eff_always & eff_annul;
                    misalign_nx = misaligned(eff_tgt[1:0]);
                end else begin
                    annul_nx = eff_annul;
                end
            end
        end

        // A trap overrides everything, including an advance in the same cycle.
        if (trap_valid) begin
            pc_nx       = align(trap_vector);
            npc_nx      = align(trap_vector) + 32'd4;
            annul_nx    = 1'b0;
            pend_nx     = 1'b0;
            misalign_nx = misaligned(trap_vector[1:0]);
            state_nx    = FLUSH;
            flush_nx    = FLUSH_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_q    <= 2'd0;
            pc_q       <= RESET_PC;
            npc_q      <= RESET_NPC;
            annul_q    <= 1'b0;
            misalign_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            flush_q    <= flush_nx;
            pc_q       <= pc_nx;
            npc_q      <= npc_nx;
            annul_q    <= annul_nx;
            misalign_q <= misalign_nx;
            pend_q     <= pend_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            pj_q   <= jmpl_valid;
            pt_q   <= br_taken | br_always;
            pal_q  <= br_always;
            pa_q   <= br_annul;
            ptgt_q <= jmpl_valid ? jmpl_target : br_target;
        end
    end

`ifdef NPC_TRACE_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 32'd0;
        end else if (advance) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign adv_count = cnt_q;
`else
    assign adv_count = 32'd0;
`endif

    assign fetch_valid = (state_q == RUN);
    assign pc          = pc_q;
    assign npc         = npc_q;
    assign fetch_annul = annul_q;
    assign redir_busy  = pend_q;
    assign misalign    = misalign_q;

`ifndef SYNTHESIS
    a_no_pulse_while_busy: assert property (@(posedge clk) disable iff (!reset)
        !(pend_q && (br_valid || jmpl_valid)))
        else $error("redirect pulse issued while redir_busy was high");
`endif

endmodule

// File: tb/tb_npc_sequencer.sv
// tb_npc_sequencer
// -----------------------------------------------------------------------------
// Scoreboard bench for npc_sequencer.
// At every rising edge a behavioural model takes the inputs and pushes the
// outputs it expects for the following cycle. A separate monitor pops each
// entry on the falling edge and compares it with the DUT. The bench runs a
// directed prologue with constant expectations, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_npc_sequencer;

    localparam logic [31:0] RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] RESET_NPC      = 32'h0000_0004;
    localparam int          TRAP_FLUSH_CYC = 1;

    localparam int MODE_BOOT  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_FLUSH = 2;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        fetch_annul;
    logic        br_valid;
    logic        br_taken;
    logic        br_always;
    logic        br_annul;
    logic [31:0] br_target;
    logic        jmpl_valid;
    logic [31:0] jmpl_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        redir_busy;
    logic        misalign;
    logic [31:0] adv_count;

    npc_sequencer #(
        .RESET_PC      (RESET_PC),
        .RESET_NPC     (RESET_NPC),
        .TRAP_FLUSH_CYC(TRAP_FLUSH_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .pc         (pc),
        .npc        (npc),
        .fetch_annul(fetch_annul),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_always  (br_always),
        .br_annul   (br_annul),
        .br_target  (br_target),
        .jmpl_valid (jmpl_valid),
        .jmpl_target(jmpl_target),
        .trap_valid (trap_valid),
        .trap_vector(trap_vector),
        .redir_busy (redir_busy),
        .misalign   (misalign),
        .adv_count  (adv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          jmpl;
        bit          taken;
        bit          ba;
        bit          annul;
        logic [31:0] tgt;
    } redir_t;

    typedef struct {
        bit          fv;
        logic [31:0] pc;
        logic [31:0] npc;
        bit          annul;
        bit          busy;
        bit          mis;
        logic [31:0] cnt;
    } exp_t;

    // Reference model state
    int          m_mode;
    int          m_dark;
    logic [31:0] m_pc;
    logic [31:0] m_npc;
    bit          m_annul;
    bit          m_mis;
    logic [31:0] m_cnt;
    redir_t      m_pend[$];
    exp_t        exp_q[$];

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = MODE_BOOT;
        m_dark  = 0;
        m_pc    = RESET_PC;
        m_npc   = RESET_NPC;
        m_annul = 1'b0;
        m_mis   = 1'b0;
        m_cnt   = 32'd0;
        m_pend.delete();
    endtask

    task automatic model_step();
        redir_t r;
        exp_t   e;
        bit     adv;
        if (!reset) begin
            model_reset();
            return;
        end
        adv   = (m_mode == MODE_RUN) && fetch_ready && !stall && !trap_valid;
        m_mis = 1'b0;
        if (m_pend.size() == 0 && (br_valid || jmpl_valid)) begin
            r.jmpl  = jmpl_valid;
            r.taken = br_taken || br_always;
            r.ba    = br_always;
            r.annul = br_annul;
            r.tgt   = jmpl_valid ? jmpl_target : br_target;
            m_pend.push_back(r);
        end
        if (trap_valid) begin
            m_pc    = trap_vector & ~32'd3;
            m_npc   = m_pc + 32'd4;
            m_annul = 1'b0;
            m_mis   = (trap_vector[1:0] != 2'b00);
            m_pend.delete();
            m_mode  = MODE_FLUSH;
            m_dark  = TRAP_FLUSH_CYC;
        end else begin
            if (m_mode == MODE_BOOT) begin
                m_mode = MODE_RUN;
            end else if (m_mode == MODE_FLUSH) begin
                m_dark--;
                if (m_dark == 0) m_mode = MODE_RUN;
            end
            if (adv) begin
                m_pc    = m_npc;
                m_npc   = m_npc + 32'd4;
                m_annul = 1'b0;
                m_cnt   = m_cnt + 32'd1;
                if (m_pend.size() != 0) begin
                    r = m_pend.pop_front();
                    if (r.jmpl || r.taken) begin
                        m_npc = r.tgt & ~32'd3;
                        m_mis = (r.tgt[1:0] != 2'b00);
                        if (!r.jmpl) m_annul = r.ba && r.annul;
                    end else begin
                        m_annul = r.annul;
                    end
                end
            end
        end
        e.fv    = (m_mode == MODE_RUN);
        e.pc    = m_pc;
        e.npc   = m_npc;
        e.annul = m_annul;
        e.busy  = (m_pend.size() != 0);
        e.mis   = m_mis;
`ifdef NPC_TRACE_EN
        e.cnt   = m_cnt;
`else
        e.cnt   = 32'd0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic monitor_step();
        exp_t e;
        if (!reset) begin
            chk("rst_pc",    pc, RESET_PC);
            chk("rst_npc",   npc, RESET_NPC);
            chk("rst_fv",    32'(fetch_valid), 32'd0);
            chk("rst_annul", 32'(fetch_annul), 32'd0);
            chk("rst_busy",  32'(redir_busy), 32'd0);
            chk("rst_mis",   32'(misalign), 32'd0);
            chk("rst_cnt",   adv_count, 32'd0);
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_fv",    32'(fetch_valid), 32'(e.fv));
            chk("sb_pc",    pc, e.pc);
            chk("sb_npc",   npc, e.npc);
            chk("sb_annul", 32'(fetch_annul), 32'(e.annul));
            chk("sb_busy",  32'(redir_busy), 32'(e.busy));
            chk("sb_mis",   32'(misalign), 32'(e.mis));
            chk("sb_cnt",   adv_count, e.cnt);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulses();
        br_valid   = 1'b0;
        br_taken   = 1'b0;
        br_always  = 1'b0;
        br_annul   = 1'b0;
        jmpl_valid = 1'b0;
        trap_valid = 1'b0;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] rnd;
        int          sel;
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b0;
        stall       = 1'b0;
        fetch_ready = 1'b1;
        br_target   = 32'd0;
        jmpl_target = 32'd0;
        trap_vector = 32'd0;
        clr_pulses();
        repeat (3) step();
        reset = 1'b1;

        // Boot and sequential flow
        step();
        @(negedge clk);
        chk("boot_pc", pc, 32'h0);
        chk("boot_npc", npc, 32'h4);
        chk("boot_fv", 32'(fetch_valid), 32'd1);
        step();
        @(negedge clk);
        chk("seq1_pc", pc, 32'h4);
        chk("seq1_npc", npc, 32'h8);
        step();
        @(negedge clk);
        chk("seq2_pc", pc, 32'h8);
        chk("seq2_npc", npc, 32'hC);
        chk("seq2_annul", 32'(fetch_annul), 32'd0);
        step();
        step();
        @(negedge clk);
        chk("pre_br_pc", pc, 32'h10);

        // Taken branch, delay slot not annulled
        br_valid = 1'b1; br_taken = 1'b1; br_annul = 1'b1; br_target = 32'h100;
        step();
        clr_pulses();
        @(negedge clk);
        chk("br_slot_pc", pc, 32'h14);
        chk("br_slot_npc", npc, 32'h100);
        chk("br_slot_annul", 32'(fetch_annul), 32'd0);
        step();
        @(negedge clk);
        chk("br_tgt_pc", pc, 32'h100);
        chk("br_tgt_npc", npc, 32'h104);

        // ba,a: delay slot annulled
        br_valid = 1'b1; br_always = 1'b1; br_annul = 1'b1; br_target = 32'h200;
        step();
        clr_pulses();
        @(negedge clk);
        chk("ba_slot_pc", pc, 32'h104);
        chk("ba_slot_annul", 32'(fetch_annul), 32'd1);
        step();
        @(negedge clk);
        chk("ba_tgt_pc", pc, 32'h200);
        chk("ba_tgt_annul", 32'(fetch_annul), 32'd0);

        // Not-taken annulling branch captured under a 3-cycle stall
        stall = 1'b1; br_valid = 1'b1; br_annul = 1'b1; br_target = 32'h7000;
        step();
        clr_pulses();
        @(negedge clk);
        chk("stall_busy0", 32'(redir_busy), 32'd1);
        chk("stall_pc0", pc, 32'h200);
        step();
        step();
        @(negedge clk);
        chk("stall_busy2", 32'(redir_busy), 32'd1);
        chk("stall_npc2", npc, 32'h204);
        stall = 1'b0;
        step();
        @(negedge clk);
        chk("nt_slot_pc", pc, 32'h204);
        chk("nt_slot_annul", 32'(fetch_annul), 32'd1);
        chk("nt_busy", 32'(redir_busy), 32'd0);
        step();
        @(negedge clk);
        chk("nt_seq_pc", pc, 32'h208);
        chk("nt_seq_annul", 32'(fetch_annul), 32'd0);

        // Trap beats an advance and a pending jmpl
        stall = 1'b1; jmpl_valid = 1'b1; jmpl_target = 32'h400;
        step();
        jmpl_valid = 1'b0; stall = 1'b0; trap_valid = 1'b1; trap_vector = 32'h800;
        step();
        clr_pulses();
        @(negedge clk);
        chk("trap_pc", pc, 32'h800);
        chk("trap_npc", npc, 32'h804);
        chk("trap_fv", 32'(fetch_valid), 32'd0);
        chk("trap_busy", 32'(redir_busy), 32'd0);
        repeat (TRAP_FLUSH_CYC) step();
        @(negedge clk);
        chk("flush_end_fv", 32'(fetch_valid), 32'd1);
        chk("flush_end_pc", pc, 32'h800);

        // Misaligned jmpl target
        jmpl_valid = 1'b1; jmpl_target = 32'h303;
        step();
        clr_pulses();
        @(negedge clk);
        chk("jmpl_npc", npc, 32'h300);
        chk("jmpl_mis", 32'(misalign), 32'd1);
        step();
        @(negedge clk);
        chk("jmpl_pc", pc, 32'h300);
        chk("jmpl_mis_clr", 32'(misalign), 32'd0);

        // Reset asserted in the middle of FLUSH
        trap_valid = 1'b1; trap_vector = 32'h900;
        step();
        clr_pulses();
        #1;
        assert_reset();
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_npc", npc, 32'h4);
        repeat (2) step();
        reset = 1'b1;

        // npc+4 wraps modulo 2^32
        step();
        trap_valid = 1'b1; trap_vector = 32'hFFFF_FFFA;
        step();
        clr_pulses();
        @(negedge clk);
        chk("wrap_pc", pc, 32'hFFFF_FFF8);
        chk("wrap_mis", 32'(misalign), 32'd1);
        repeat (TRAP_FLUSH_CYC) step();
        step();
        @(negedge clk);
        chk("wrap_pc2", pc, 32'hFFFF_FFFC);
        chk("wrap_npc2", npc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clr_pulses();
            if (i == 1500) begin
                assert_reset();
                repeat (2) step();
                reset = 1'b1;
            end
            stall       = ($urandom_range(0, 9) == 0);
            fetch_ready = ($urandom_range(0, 9) != 0);
            if (m_pend.size() == 0) begin
                sel = $urandom_range(0, 19);
                rnd = $urandom() & 32'h0000_FFFF;
                if ($urandom_range(0, 3) != 0) rnd = rnd & ~32'd3;
                if (sel < 4) begin
                    br_valid  = 1'b1;
                    br_taken  = $urandom_range(0, 1) == 1;
                    br_always = $urandom_range(0, 3) == 0;
                    br_annul  = $urandom_range(0, 1) == 1;
                    br_target = rnd;
                end else if (sel < 6) begin
                    jmpl_valid  = 1'b1;
                    jmpl_target = rnd;
                end
            end
            if ($urandom_range(0, 49) == 0) begin
                trap_valid  = 1'b1;
                trap_vector = $urandom();
            end
            step();
        end
        clr_pulses();
        stall = 1'b0;
        fetch_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
